// File: rtl/dual_run_pkg.sv
// Shared types and defaults for the dual-core run sequencer.
package dual_run_pkg;

    localparam int DEF_CNT_W          = 32;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } run_state_e;

    typedef logic [DEF_CNT_W-1:0] core_cnt_t;

endpackage

// File: rtl/dual_run_sequencer_core_budget_ctr.sv
// One core's fetch/retire counters, saturating at the latched budget, plus its
// look-ahead budget-reached flags and sticky overrun flag.
module core_budget_ctr
    import dual_run_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             fetch_i,
    input  logic             retire_i,
    input  logic [CNT_W-1:0] budget_i,
    output logic [CNT_W-1:0] fcnt_nx_o,
    output logic             fetch_done_nx_o,
    output logic             retire_done_nx_o,
    output logic             overrun_o
);

    logic [CNT_W-1:0] fcnt_q;
    logic [CNT_W-1:0] rcnt_q;
    logic [CNT_W-1:0] rcnt_nx;
    logic             overrun_q;
    logic             overrun_nx;

    always_comb begin
        fcnt_nx_o  = fcnt_q;
        rcnt_nx    = rcnt_q;
        overrun_nx = overrun_q;
        if (clear_i) begin
            fcnt_nx_o  = '0;
            rcnt_nx    = '0;
            overrun_nx = 1'b0;
        end else begin
            if (fetch_i && (fcnt_q < budget_i)) begin
                fcnt_nx_o = fcnt_q + CNT_W'(1);
            end
            // A retire beyond the budget is flagged rather than counted.
            if (retire_i) begin
                if (rcnt_q < budget_i) begin
                    rcnt_nx = rcnt_q + CNT_W'(1);
                end else begin
                    overrun_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fcnt_q    <= '0;
            rcnt_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            fcnt_q    <= fcnt_nx_o;
            rcnt_q    <= rcnt_nx;
            overrun_q <= overrun_nx;
        end
    end

    assign fetch_done_nx_o  = (fcnt_nx_o == budget_i);
    assign retire_done_nx_o = (rcnt_nx >= budget_i);
    assign overrun_o        = overrun_q;

endmodule

// File: rtl/dual_run_sequencer.sv
// Sequences two cores through one bounded run: budgeted fetch gating, drain,
// idle timeout. Optional fetch-skew bound between cores when RUN_SKEW_EN is defined.
module dual_run_sequencer
    import dual_run_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_SKEW       = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] budget_i,
    input  logic [1:0]       fetch_i,
    input  logic [1:0]       retire_i,
    output logic [1:0]       enable_o,
    output logic             busy_o,
    output logic             finished_o,
    output logic             timeout_o,
    output logic             overrun_o,
    output run_state_e       state_o
);

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    run_state_e        state_q;
    logic [CNT_W-1:0]  budget_q;
    logic [IDLE_W-1:0] idle_q;
    logic [1:0]        enable_q;
    logic [1:0]        enable_nx;
    logic [1:0]        skew_block;
    logic [1:0]        fetch_done_nx;
    logic [1:0]        retire_done_nx;
    logic [1:0]        overrun;
    logic [CNT_W-1:0]  fcnt_nx [2];

    logic start_ok;
    logic in_run;
    logic active;
    logic any_retire;
    logic idle_expired;

    assign start_ok     = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                      (state_q == ST_TIMEOUT));
    assign in_run       = (state_q == ST_RUN);
    assign active       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign any_retire   = |retire_i;
    assign idle_expired = active && !any_retire && (idle_q == IDLE_LAST);

    for (genvar k = 0; k < 2; k++) begin : g_core
        core_budget_ctr #(.CNT_W(CNT_W)) u_ctr (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .clear_i         (start_ok),
            .fetch_i         (in_run && fetch_i[k] && enable_q[k]),
            .retire_i        (active && retire_i[k]),
            .budget_i        (budget_q),
            .fcnt_nx_o       (fcnt_nx[k]),
            .fetch_done_nx_o (fetch_done_nx[k]),
            .retire_done_nx_o(retire_done_nx[k]),
            .overrun_o       (overrun[k])
        );
    end

`ifdef RUN_SKEW_EN
    localparam logic [CNT_W:0] SKEW_EXT = (CNT_W + 1)'(MAX_SKEW);
`else
    logic unused_skew;
    assign unused_skew = (MAX_SKEW >= 1);
`endif

    // Gate on the counts being registered this edge so no extra fetch slips through.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            skew_block[k] = 1'b0;
`ifdef RUN_SKEW_EN
            skew_block[k] = (fcnt_nx[1-k] < budget_q) &&
                            ({1'b0, fcnt_nx[k]} >= ({1'b0, fcnt_nx[1-k]} + SKEW_EXT));
`endif
            enable_nx[k] = (fcnt_nx[k] < budget_q) && !skew_block[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            budget_q <= '0;
            idle_q   <= '0;
            enable_q <= 2'b00;
        end else begin
            if (active) begin
                if (any_retire) begin
                    idle_q <= '0;
                end else if (idle_q != IDLE_LAST) begin
                    idle_q <= idle_q + IDLE_W'(1);
                end
            end
            case (state_q)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start_i) begin
                        budget_q <= budget_i;
                        idle_q   <= '0;
                        if (budget_i == '0) begin
                            state_q  <= ST_DRAIN;
                            enable_q <= 2'b00;
                        end else begin
                            state_q  <= ST_RUN;
                            enable_q <= 2'b11;
                        end
                    end
                end
                ST_RUN: begin
                    if (&fetch_done_nx) begin
                        state_q  <= ST_DRAIN;
                        enable_q <= 2'b00;
                    end else if (idle_expired) begin
                        state_q  <= ST_TIMEOUT;
                        enable_q <= 2'b00;
                    end else begin
                        enable_q <= enable_nx;
                    end
                end
                ST_DRAIN: begin
                    enable_q <= 2'b00;
                    if (&retire_done_nx) begin
                        state_q <= ST_DONE;
                    end else if (idle_expired) begin
                        state_q <= ST_TIMEOUT;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    enable_q <= 2'b00;
                end
            endcase
        end
    end

    assign enable_o   = enable_q;
    assign busy_o     = active;
    assign finished_o = (state_q == ST_DONE);
    assign timeout_o  = (state_q == ST_TIMEOUT);
    assign overrun_o  = |overrun;
    assign state_o    = state_q;

endmodule

// File: tb/tb_dual_run_sequencer.sv
// Directed bench for dual_run_sequencer: vector table for the main runs plus
// hand-written timeout, reset-mid-run and skew sequences.
module tb_dual_run_sequencer;
    import dual_run_pkg::*;

    localparam int CNT_W   = 8;
    localparam int TO_CYC  = 16;
    localparam int N_VEC   = 24;
    localparam int OUT_W   = 6;

    typedef struct packed {
        logic             start;
        logic [CNT_W-1:0] budget;
        logic [1:0]       fetch;
        logic [1:0]       retire;
        logic [OUT_W-1:0] exp;   // {enable[1:0], busy, finished, timeout, overrun}
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] budget;
    logic [1:0]       fetch;
    logic [1:0]       retire;
    logic [1:0]       enable;
    logic             busy;
    logic             finished;
    logic             timeout;
    logic             overrun;
    run_state_e       state;

    vec_t             vecs [N_VEC];
    logic [OUT_W-1:0] exp_q [$];
    int               n_checks;
    int               n_fail;

    dual_run_sequencer #(
        .CNT_W         (CNT_W),
        .TIMEOUT_CYCLES(TO_CYC),
        .MAX_SKEW      (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .budget_i  (budget),
        .fetch_i   (fetch),
        .retire_i  (retire),
        .enable_o  (enable),
        .busy_o    (busy),
        .finished_o(finished),
        .timeout_o (timeout),
        .overrun_o (overrun),
        .state_o   (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] outs();
        return {enable, busy, finished, timeout, overrun};
    endfunction

    task automatic check(input string name, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (outs() !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, outs(), exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic s, input logic [CNT_W-1:0] b,
                        input logic [1:0] f, input logic [1:0] r);
        start  = s;
        budget = b;
        fetch  = f;
        retire = r;
        @(posedge clk);
        #1;
        start  = 1'b0;
        fetch  = 2'b00;
        retire = 2'b00;
    endtask

    initial begin
        int to_cycle;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        budget   = '0;
        fetch    = 2'b00;
        retire   = 2'b00;

        // Budget 3 run, fetch every cycle, retire three each
        vecs[0]  = '{1'b1, 8'd3, 2'b00, 2'b00, 6'b111000};
        vecs[1]  = '{1'b0, 8'd0, 2'b11, 2'b00, 6'b111000};
        vecs[2]  = '{1'b0, 8'd0, 2'b11, 2'b00, 6'b111000};
        vecs[3]  = '{1'b0, 8'd0, 2'b11, 2'b00, 6'b001000};
        vecs[4]  = '{1'b0, 8'd0, 2'b11, 2'b11, 6'b001000};
        vecs[5]  = '{1'b0, 8'd0, 2'b00, 2'b11, 6'b001000};
        vecs[6]  = '{1'b0, 8'd0, 2'b00, 2'b11, 6'b000100};
        vecs[7]  = '{1'b0, 8'd0, 2'b00, 2'b00, 6'b000100};
        // Budget 0: DRAIN then DONE with enables never raised
        vecs[8]  = '{1'b1, 8'd0, 2'b00, 2'b00, 6'b001000};
        vecs[9]  = '{1'b0, 8'd0, 2'b00, 2'b00, 6'b000100};
        vecs[10] = '{1'b0, 8'd0, 2'b00, 2'b00, 6'b000100};
        // Budget 2, core0 over-retires, core1 completes later
        vecs[11] = '{1'b1, 8'd2, 2'b00, 2'b00, 6'b111000};
        vecs[12] = '{1'b0, 8'd0, 2'b11, 2'b00, 6'b111000};
        vecs[13] = '{1'b0, 8'd0, 2'b11, 2'b00, 6'b001000};
        vecs[14] = '{1'b0, 8'd0, 2'b00, 2'b01, 6'b001000};
        vecs[15] = '{1'b0, 8'd0, 2'b00, 2'b01, 6'b001000};
        vecs[16] = '{1'b0, 8'd0, 2'b00, 2'b01, 6'b001001};
        vecs[17] = '{1'b0, 8'd0, 2'b00, 2'b10, 6'b001001};
        vecs[18] = '{1'b0, 8'd0, 2'b00, 2'b10, 6'b000101};
        // Budget 1: restart clears overrun, per-core enable drop, start ignored in DRAIN
        vecs[19] = '{1'b1, 8'd1, 2'b00, 2'b00, 6'b111000};
        vecs[20] = '{1'b0, 8'd0, 2'b01, 2'b00, 6'b101000};
        vecs[21] = '{1'b0, 8'd0, 2'b11, 2'b00, 6'b001000};
        vecs[22] = '{1'b1, 8'd4, 2'b00, 2'b00, 6'b001000};
        vecs[23] = '{1'b0, 8'd0, 2'b00, 2'b11, 6'b000100};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 6'b000000);
        check_int("reset_state", int'(state), int'(ST_IDLE));
        rst_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            exp_q.push_back(vecs[i].exp);
            step(vecs[i].start, vecs[i].budget, vecs[i].fetch, vecs[i].retire);
            check($sformatf("vec%0d", i), exp_q.pop_front());
        end

        // Timeout: budget 5, no activity, expect TIMEOUT TO_CYC cycles after start
        step(1'b1, 8'd5, 2'b00, 2'b00);
        check("to_start", 6'b111000);
        to_cycle = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (timeout) begin
                to_cycle = i;
                break;
            end
        end
        check_int("to_latency", to_cycle, TO_CYC);
        check("to_outputs", 6'b000010);
        step(1'b0, 8'd0, 2'b00, 2'b00);
        check("to_held", 6'b000010);

        // Reset in RUN with fcnt = {2,1}, then a clean budget-1 run
        step(1'b1, 8'd3, 2'b00, 2'b00);
        step(1'b0, 8'd0, 2'b11, 2'b00);
        step(1'b0, 8'd0, 2'b01, 2'b00);
        check("pre_reset_run", 6'b111000);
        rst_n = 1'b0;
        step(1'b0, 8'd0, 2'b00, 2'b00);
        check("mid_reset_outputs", 6'b000000);
        check_int("mid_reset_state", int'(state), int'(ST_IDLE));
        rst_n = 1'b1;
        step(1'b1, 8'd1, 2'b00, 2'b00);
        check("restart_run", 6'b111000);
        step(1'b0, 8'd0, 2'b11, 2'b00);
        check("restart_drain", 6'b001000);
        step(1'b0, 8'd0, 2'b00, 2'b11);
        check("restart_done", 6'b000100);

        // Only core0 fetching, budget 5
        step(1'b1, 8'd5, 2'b00, 2'b00);
        check("skew_start", 6'b111000);
        step(1'b0, 8'd0, 2'b01, 2'b00);
        check("skew_f1", 6'b111000);
        step(1'b0, 8'd0, 2'b01, 2'b00);
`ifdef RUN_SKEW_EN
        check("skew_gate", 6'b101000);
        step(1'b0, 8'd0, 2'b01, 2'b00);
        check("skew_hold", 6'b101000);
        step(1'b0, 8'd0, 2'b10, 2'b00);
        check("skew_release", 6'b111000);
`else
        check("noskew_f2", 6'b111000);
        step(1'b0, 8'd0, 2'b01, 2'b00);
        check("noskew_f3", 6'b111000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_run_sequencer.md
# dual_run_sequencer

Sequences the two core instances of the relational-verification harness through one bounded run. Latches an instruction budget, gates each core's fetch enable until that core has fetched exactly the budget, waits for both cores to retire the budget, then raises `finished_o`. It also watches for a stalled run (timeout) and, when configured, bounds the fetch skew between the two cores. It sits between the testbench top and the fetch-gating inputs of both cores.

## Interface
Reset is synchronous and active-low on `rst_ni`, sampled on the rising edge of `clk_i`. There is one clock.

Parameters:
- `CNT_W`, 32: width of the budget and all counters.
- `TIMEOUT_CYCLES`, 4096: number of idle cycles with no retire from either core before a timeout.
- `MAX_SKEW`, 4: maximum allowed fetch-count lead of one core over the other. Used only with `RUN_SKEW_EN`. Must be ≥1.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  synchronous active-low reset.
- `start_i`  in  1  pulse; starts a run. Accepted in IDLE, DONE or TIMEOUT.
- `budget_i`  in  CNT_W  instructions per core; sampled on the accepted `start_i`.
- `fetch_i`  in  2  per-core fetch-accepted strobe.
- `retire_i`  in  2  per-core retire strobe (at most one retire per core per cycle).
- `enable_o`  out  2  per-core fetch enable; registered.
- `busy_o`  out  1  high in RUN or DRAIN.
- `finished_o`  out  1  high in DONE.
- `timeout_o`  out  1  high in TIMEOUT.
- `overrun_o`  out  1  sticky; a core retired more than the budget. Cleared on start or reset.

## Operation
- States are IDLE, RUN, DRAIN, DONE, TIMEOUT. Reset value of every output is 0, and the state is IDLE.
- IDLE/DONE/TIMEOUT → RUN on `start_i`:
  - latch `budget_i`;
  - clear the fetch, retire and idle counters;
  - clear `overrun_o`.
- A budget of 0 goes to DRAIN instead of RUN, and `enable_o` stays 0.
- RUN:
  - `enable_o[k]` = (`fcnt[k]` < budget), ANDed with the skew gate.
  - A fetch counts only when `fetch_i[k]` && `enable_o[k]`. Fetches while the enable is low are ignored.
  - Move to DRAIN when both `fcnt` equal the budget.
- DRAIN:
  - `enable_o` = 0.
  - Move to DONE when both `rcnt` ≥ budget.
- Retire counting:
  - `rcnt[k]` increments on `retire_i[k]` in RUN and DRAIN and saturates at the budget.
  - A retire while `rcnt[k]` == budget sets `overrun_o`; the run continues.
- Idle counter:
  - Clears on any retire.
  - Otherwise increments in RUN and DRAIN.
  - Reaching `TIMEOUT_CYCLES`−1 moves the block to TIMEOUT and drops `enable_o` to 0.
- Timeout and completion in the same cycle: DONE wins.
- `start_i` in RUN or DRAIN is ignored.
- Reset mid-run: the block returns to IDLE immediately on the next edge, and all counters clear.
- Counters are CNT_W bits, unsigned, with no wrap because they saturate at the budget. The idle counter is `$clog2(TIMEOUT_CYCLES)` bits.

## Timing
- `enable_o` goes high 1 cycle after the accepted `start_i`.
- The fetch that makes `fcnt[k]` equal the budget drops `enable_o[k]` on the next edge. There is no extra fetch.
- `finished_o` goes high 1 cycle after the retire that completes the second core's budget.
- `finished_o` and `timeout_o` are held until `start_i` or reset.
- Simultaneous fetches on both cores in one cycle are both counted.

## Configuration
- `RUN_SKEW_EN` defined:
  - `enable_o[k]` is also forced low while `fcnt[k]` − `fcnt[1−k]` ≥ `MAX_SKEW`.
  - The gate is evaluated on the registered counts.
  - A core that has finished its budget never gates the other.
- `RUN_SKEW_EN` undefined: the cores fetch independently and `MAX_SKEW` is unused.

## Structure
- Package `dual_run_pkg` holds:
  - the `run_state_e` enum;
  - the default `CNT_W` and `TIMEOUT_CYCLES` localparams;
  - the `core_cnt_t` typedef.
- Sub-module `core_budget_ctr` is instantiated twice. It holds one core's fetch/retire counters, its saturation logic, its budget-reached flag and its overrun flag.
- The top level holds the FSM, the idle counter and the skew gate.

## Test plan
- Budget 3, both cores fetch every cycle, then retire 3 each → `enable_o` = 2'b11 for exactly 3 cycles; DRAIN; `finished_o` 1 cycle after the last retire.
- Budget 0, start → `enable_o` stays 0; DONE on the cycle after DRAIN entry.
- Budget 5, no retires after start → `timeout_o` after `TIMEOUT_CYCLES` cycles; `enable_o` = 0.
- Budget 2, core0 retires 3 times → `overrun_o` = 1 and `finished_o` still asserts once core1 retires 2.
- `RUN_SKEW_EN`, `MAX_SKEW` 2, only core0 fetching → `enable_o[0]` drops after 2 fetches and reasserts after core1 fetches once.
- Reset asserted in RUN with `fcnt` = {2,1} → next cycle IDLE, all outputs 0; a restart with budget 1 completes normally.
